// File: rtl/venera_pkg.sv
// Shared constants for the venera fetch path: default geometry and the
// control-request priority encoding used by the program sequencer.
package venera_pkg;

   localparam int unsigned DEFAULT_ADDR_W      = 8;
   localparam int unsigned DEFAULT_PHASES      = 4;
   localparam int unsigned DEFAULT_STACK_DEPTH = 4;

   localparam logic [1:0] CTRL_NONE = 2'd0;
   localparam logic [1:0] CTRL_JUMP = 2'd1;
   localparam logic [1:0] CTRL_CALL = 2'd2;
   localparam logic [1:0] CTRL_RET  = 2'd3;

   // ret beats call beats jump; losers are dropped entirely
   function automatic logic [1:0] ctrl_decode(input logic ret, input logic call,
                                              input logic jump);
      if (ret) begin
         return CTRL_RET;
      end else if (call) begin
         return CTRL_CALL;
      end else if (jump) begin
         return CTRL_JUMP;
      end
      return CTRL_NONE;
   endfunction

endpackage

// File: rtl/program_sequencer_if.sv
// Control/decode side <-> program sequencer bundle; the master is the decode unit,
// the slave is the sequencer driving the instruction-memory read port.
interface program_sequencer_if #(
   parameter int unsigned ADDR_W  = venera_pkg::DEFAULT_ADDR_W,
   parameter int unsigned DEPTH_W = $clog2(venera_pkg::DEFAULT_STACK_DEPTH + 1)
);
   logic              stall;
   logic              jump_valid;
   logic              call_valid;
   logic              ret_valid;
   logic [ADDR_W-1:0] target;
   logic              rd;
   logic [ADDR_W-1:0] address;
   logic [DEPTH_W-1:0] depth;
   logic              stack_ovf;
   logic              stack_unf;

   modport master (
      output stall, jump_valid, call_valid, ret_valid, target,
      input  rd, address, depth, stack_ovf, stack_unf
   );

   modport slave (
      input  stall, jump_valid, call_valid, ret_valid, target,
      output rd, address, depth, stack_ovf, stack_unf
   );
endinterface

// File: rtl/return_stack.sv
// Hardware return-address LIFO; silently ignores push when full and pop when empty.
module return_stack #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned DEPTH_W = $clog2(DEPTH + 1),
   localparam int unsigned IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_push,
   input  logic               i_pop,
   input  logic [WIDTH-1:0]   i_data,
   output logic [WIDTH-1:0]   o_top,
   output logic               o_full,
   output logic               o_empty,
   output logic [DEPTH_W-1:0] o_depth
);
   logic [WIDTH-1:0]   mem [DEPTH];
   logic [DEPTH_W-1:0] count_q, count_d;
   logic [DEPTH_W-1:0] top_cnt;
   logic [IDX_W-1:0]   push_idx, top_idx;
   logic               do_push, do_pop;

   assign o_full   = (count_q == DEPTH_W'(DEPTH));
   assign o_empty  = (count_q == '0);
   assign o_depth  = count_q;
   assign top_cnt  = count_q - DEPTH_W'(1);
   assign push_idx = IDX_W'(count_q);
   assign top_idx  = IDX_W'(top_cnt);
   assign o_top    = mem[top_idx];

   assign do_pop  = i_pop & ~o_empty;
   assign do_push = i_push & ~o_full & ~i_pop;

   always_comb begin
      count_d = count_q;
      if (do_pop) begin
         count_d = count_q - DEPTH_W'(1);
      end else if (do_push) begin
         count_d = count_q + DEPTH_W'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   // Contents need no reset: nothing is readable until pushed.
   always_ff @(posedge i_clk) begin
      if (do_push && !i_reset) begin
         mem[push_idx] <= i_data;
      end
   end

endmodule

// File: rtl/program_sequencer.sv
// Fetch-address generator: one read strobe every PHASES cycles, with stall,
// jump and call/return through a hardware return stack with sticky error flags.
module program_sequencer
   import venera_pkg::*;
#(
   parameter int unsigned       ADDR_W      = DEFAULT_ADDR_W,
   parameter int unsigned       PHASES      = DEFAULT_PHASES,
   parameter int unsigned       STACK_DEPTH = DEFAULT_STACK_DEPTH,
   parameter logic [ADDR_W-1:0] RESET_PC    = '0,
   localparam int unsigned      PH_W        = (PHASES > 1) ? $clog2(PHASES) : 1
) (
   input logic i_clk,
   input logic i_reset,
   program_sequencer_if.slave bus
);
   logic [PH_W-1:0]   phase_q, phase_d;
   logic [ADDR_W-1:0] pc_q, pc_d;
   logic              ovf_q, ovf_d;
   logic              unf_q, unf_d;
   logic [1:0]        ctrl;
   logic              ctrl_event;
   logic              last_phase;
   logic [ADDR_W-1:0] stack_top;
   logic              stack_full, stack_empty;

   assign ctrl       = ctrl_decode(bus.ret_valid, bus.call_valid, bus.jump_valid);
   assign ctrl_event = (ctrl != CTRL_NONE);
   assign last_phase = (phase_q == PH_W'(PHASES - 1));

   assign bus.rd        = last_phase & ~bus.stall & ~ctrl_event & ~i_reset;
   assign bus.address   = pc_q;
   assign bus.stack_ovf = ovf_q;
   assign bus.stack_unf = unf_q;

   return_stack #(
      .WIDTH (ADDR_W),
      .DEPTH (STACK_DEPTH)
   ) u_stack (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_push  (ctrl == CTRL_CALL),
      .i_pop   (ctrl == CTRL_RET),
      .i_data  (pc_q),
      .o_top   (stack_top),
      .o_full  (stack_full),
      .o_empty (stack_empty),
      .o_depth (bus.depth)
   );

   always_comb begin
      phase_d = phase_q;
      pc_d    = pc_q;
      ovf_d   = ovf_q;
      unf_d   = unf_q;
      unique case (ctrl)
         CTRL_RET: begin
            phase_d = '0;
            if (stack_empty) begin
               unf_d = 1'b1;
            end else begin
               pc_d = stack_top;
            end
         end
         CTRL_CALL: begin
            phase_d = '0;
            pc_d    = bus.target;
            if (stack_full) begin
               ovf_d = 1'b1;
            end
         end
         CTRL_JUMP: begin
            phase_d = '0;
            pc_d    = bus.target;
         end
         CTRL_NONE: begin
            if (!bus.stall) begin
               if (last_phase) begin
                  phase_d = '0;
                  pc_d    = pc_q + ADDR_W'(1);
               end else begin
                  phase_d = phase_q + PH_W'(1);
               end
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         phase_q <= '0;
         pc_q    <= RESET_PC;
         ovf_q   <= 1'b0;
         unf_q   <= 1'b0;
      end else begin
         phase_q <= phase_d;
         pc_q    <= pc_d;
         ovf_q   <= ovf_d;
         unf_q   <= unf_d;
      end
   end

endmodule

// File: doc/program_sequencer.md
Name: program_sequencer

Overview:
- Parametrised fetch-address generator for the venera CPU core. Successor to the fixed 8-bit, 4-phase fetch counter.
- Produces one instruction-memory read strobe every PHASES cycles, with the program counter (PC) on the address bus.
- Adds stall, absolute jump, and call/return through an internal hardware return-address stack (LIFO), with sticky overflow/underflow error flags.
- Sits between the control/decode unit (source of jump/call/ret/stall) and the instruction-memory read port.

Parameters:
- ADDR_W, 8, width of PC and address bus (2..16)
- PHASES, 4, clock cycles per fetch (1..16)
- STACK_DEPTH, 4, number of return-stack entries (1..16)
- RESET_PC, 0, PC value after reset, ADDR_W bits

Ports:
- i_clk  in  1  clock
- i_reset  in  1  reset, synchronous, active-high
- i_stall  in  1  freeze phase counter and PC
- i_jump_valid  in  1  one-cycle request: load PC from i_target
- i_call_valid  in  1  one-cycle request: push PC, then load PC from i_target
- i_ret_valid  in  1  one-cycle request: pop stack top into PC
- i_target  in  ADDR_W  jump/call destination
- o_rd  out  1  read strobe, one cycle per fetch
- o_address  out  ADDR_W  current PC
- o_depth  out  $clog2(STACK_DEPTH+1)  number of occupied stack entries
- o_stack_ovf  out  1  sticky: call issued while stack full
- o_stack_unf  out  1  sticky: ret issued while stack empty

Behaviour:
- Reset values (any cycle with i_reset=1, including mid-operation; overrides all other inputs):
  - phase=0, PC=RESET_PC, depth=0, o_rd=0, o_stack_ovf=0, o_stack_unf=0.
  - Stack contents are don't-care.
- Phase counter:
  - Counts 0..PHASES-1, then wraps to 0.
  - Advances only in cycles with no stall and no control event.
- o_rd is combinational: o_rd = (phase==PHASES-1) & ~i_stall & ~(any control event).
  - First o_rd after reset release: the PHASES-th cycle (cycle index PHASES-1), with o_address=RESET_PC.
  - PHASES=1: o_rd is high every non-stalled, non-control cycle.
- Increment:
  - On the edge closing an o_rd cycle, PC <= PC+1, modulo 2^ADDR_W.
  - All-ones wraps to 0 silently.
- Stall: phase and PC hold, and o_rd is forced to 0.
- Control events (ret, call, jump):
  - Accepted in any cycle, including stalled and o_rd-eligible cycles.
  - Priority: ret > call > jump. Lower-priority requests in the same cycle are ignored entirely.
  - Every accepted event sets phase <= 0 and suppresses o_rd that cycle. The next fetch occurs PHASES cycles later, at the new PC.
- Jump: PC <= i_target.
- Call:
  - Stack not full: push the current PC (already the post-fetch return address), depth+1, PC <= i_target.
  - Stack full: PC <= i_target, no push, depth unchanged, o_stack_ovf <= 1.
- Ret:
  - Stack not empty: PC <= top entry, depth-1.
  - Stack empty: PC unchanged, o_stack_unf <= 1.
- Error flags are cleared only by reset.
- All state updates occur at the rising edge of i_clk; o_address is a direct register output.

Decomposition:
- Shared package (venera_pkg):
  - Default ADDR_W, PHASES and STACK_DEPTH constants.
  - Control-priority encoding localparams: CTRL_NONE, CTRL_JUMP, CTRL_CALL, CTRL_RET.
- Sub-module return_stack (params WIDTH, DEPTH):
  - Inputs i_push, i_pop, i_data.
  - Outputs o_top, o_full, o_empty, o_depth.
  - Guards internally against push-when-full and pop-when-empty.
- program_sequencer keeps the phase counter, PC, priority decode and error flags.

Test Plan (ADDR_W=8, PHASES=4, STACK_DEPTH=4, RESET_PC=0):
- Reset release, free-run 16 cycles -> o_rd high at cycles 3,7,11,15 with o_address 0x00,0x01,0x02,0x03; depth=0, flags=0.
- i_stall high for 3 cycles covering cycle 7 -> o_rd suppressed, PC holds 0x01; o_rd resumes at cycle 10 with address 0x01.
- Jump to 0xFE in an o_rd-eligible cycle -> no strobe that cycle; next strobes at +4 and +8 cycles, addresses 0xFE then 0xFF; following strobe address 0x00 (wrap).
- After fetches 0x00-0x04, call 0x40 -> depth=1, PC=0x40; fetch 0x40, 0x41; ret -> PC=0x05, depth=0; next strobe address 0x05.
- 5 consecutive calls -> depth saturates at 4, o_stack_ovf=1 after the 5th; 5 rets -> 4 return correct addresses LIFO, 5th sets o_stack_unf=1 with PC unchanged.
- Same cycle: ret+call+jump with depth=1 -> only ret applied; then assert i_reset mid-phase=2 -> next cycle PC=0, depth=0, flags=0, o_rd=0.
